arrow_row_scheduler: RTL and testbench
======================================

// Module: arrow_row_scheduler
// PURPOSE
//   Sequences note-chart playback for the arrow-scroll datapath. Counts VGA frames,
//   and every FRAMES_PER_ROW frames fetches one 4-arrow row from the chart ROM,
//   pulses shift_up so the game table scrolls, and hands the new row to the strip
//   loader. Replaces the free-running shift clock; sits between vsync and GameManager/GameTable.
// PARAMETERS
//   FRAMES_PER_ROW  8    frames between row shifts (>=1)
//   ADDR_W          8    chart ROM address width
//   CHART_DEPTH     256  rows in chart ROM (<= 2**ADDR_W)
// PORTS
//   clk           in   1       system clock (50 MHz)
//   reset         in   1       asynchronous, active-high
//   vs            in   1       VGA vertical sync (async to logic, level)
//   start         in   1       1-cycle pulse: begin/restart playback
//   pause         in   1       level: freeze frame counting
//   chart_addr    out  ADDR_W  chart ROM address
//   chart_data    in   5       ROM data, 1-cycle latency; [4]=end marker, [3:0]=L,D,U,R arrows
//   shift_up      out  1       1-cycle pulse: scroll table up one row
//   strip_arrows  out  4       arrows of new row, held until next load
//   strip_valid   out  1       1-cycle pulse, coincident with shift_up
//   row_count     out  16      rows issued since start, saturates at 16'hFFFF
//   busy          out  1       1 in RUN/FETCH/CAPTURE
//   done          out  1       1 in DONE
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; chart_addr=0, shift_up=0, strip_arrows=0,
//     strip_valid=0, row_count=0, busy=0, done=0, frame_cnt=0; vs sync flops and
//     edge-detect register reset to 1 (no false tick on release).
//   vs -> 2-flop synchronizer -> frame_tick = 1-cycle pulse on synced 0->1 edge.
//   States:
//   IDLE: start -> frame_cnt=0, chart_addr=0, row_count=0, strip_arrows=0 -> RUN.
//   RUN: frame_tick & !pause: frame_cnt==FRAMES_PER_ROW-1 -> frame_cnt=0, FETCH;
//     else frame_cnt++. pause=1 holds frame_cnt; ticks while paused are lost.
//   FETCH: 1 wait cycle for ROM (chart_addr stable since RUN) -> CAPTURE.
//   CAPTURE: chart_data[4]=1 -> DONE, no shift_up/strip_valid.
//     else next cycle: shift_up=1, strip_valid=1, strip_arrows=chart_data[3:0],
//     row_count++ (sat.); chart_addr==CHART_DEPTH-1 -> DONE, else chart_addr++ -> RUN.
//   DONE: done=1, chart_addr held; start -> same init as IDLE -> RUN.
//   Latency: frame_tick (synced edge) completing count -> shift_up 3 cycles later
//     (RUN->FETCH->CAPTURE->pulse registered).
//   start while busy: ignored. pause does not abort FETCH/CAPTURE (row already committed).
//   frame_tick during FETCH/CAPTURE: dropped (frames are ~833k cycles apart; never occurs).
//   FRAMES_PER_ROW=1: every unpaused tick fetches a row.
//   Row of all zeros (no arrows) is a valid row: shift_up still pulses.
//   busy and done are never 1 together; shift_up high exactly 1 cycle per row.
// TESTING
//   Reset, start, 8 vs rising edges, ROM row0=5'b0_1010 -> 1 shift_up, strip_arrows=4'b1010, row_count=1, chart_addr=1.
//   pause high across frames 3..6 of a period -> shift_up delayed by exactly the paused ticks; frame_cnt held.
//   ROM row2=5'b1_0000 -> after row1 shift, next period enters DONE, no shift_up, done=1, busy=0, row_count=2.
//   CHART_DEPTH=4, no end marker -> exactly 4 shift_up pulses, then done=1, chart_addr=3.
//   Assert reset mid-FETCH -> all outputs 0 immediately; no shift_up after release; vs held high on release -> no tick.
//   start pulsed during RUN -> ignored; start in DONE -> row_count=0, chart_addr=0, playback restarts.

Source files
------------

// File: rtl/arrow_row_scheduler.sv
//------------------------------------------------------------------------------
// arrow_row_scheduler: frame-paced chart-row fetch, table scroll and strip load.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arrow_row_scheduler #(
    parameter int FRAMES_PER_ROW = 8,
    parameter int ADDR_W         = 8,
    parameter int CHART_DEPTH    = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] chart_addr,
    input  logic [4:0]        chart_data,
    output logic              shift_up,
    output logic [3:0]        strip_arrows,
    output logic              strip_valid,
    output logic [15:0]       row_count,
    output logic              busy,
    output logic              done
);

    localparam int                c_cnt_w     = (FRAMES_PER_ROW > 1) ? $clog2(FRAMES_PER_ROW) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(FRAMES_PER_ROW - 1);
    localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(CHART_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_FETCH   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [c_cnt_w-1:0]  frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0]   chart_addr_q, chart_addr_d;
    logic                shift_up_q, shift_up_d;
    logic                strip_valid_q, strip_valid_d;
    logic [3:0]          strip_arrows_q, strip_arrows_d;
    logic [15:0]         row_count_q, row_count_d;
    logic                vs_s1_q, vs_s2_q, vs_prev_q;
    logic                frame_tick;

    // Sync chain resets high so a vs already high at release is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            vs_s1_q   <= vs;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    assign frame_tick = vs_s2_q & ~vs_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            frame_cnt_q    <= '0;
            chart_addr_q   <= '0;
            shift_up_q     <= 1'b0;
            strip_valid_q  <= 1'b0;
            strip_arrows_q <= 4'd0;
            row_count_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            chart_addr_q   <= chart_addr_d;
            shift_up_q     <= shift_up_d;
            strip_valid_q  <= strip_valid_d;
            strip_arrows_q <= strip_arrows_d;
            row_count_q    <= row_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        chart_addr_d   = chart_addr_q;
        shift_up_d     = 1'b0;
        strip_valid_d  = 1'b0;
        strip_arrows_d = strip_arrows_q;
        row_count_d    = row_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    frame_cnt_d    = '0;
                    chart_addr_d   = '0;
                    row_count_d    = 16'd0;
                    strip_arrows_d = 4'd0;
                    state_d        = S_RUN;
                end
            end
            S_RUN: begin
                if (frame_tick && !pause) begin
                    if (frame_cnt_q == c_last_cnt) begin
                        frame_cnt_d = '0;
                        state_d     = S_FETCH;
                    end else begin
                        frame_cnt_d = frame_cnt_q + c_cnt_w'(1);
                    end
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // End marker terminates playback without scrolling the table.
                if (chart_data[4]) begin
                    state_d = S_DONE;
                end else begin
                    shift_up_d     = 1'b1;
                    strip_valid_d  = 1'b1;
                    strip_arrows_d = chart_data[3:0];
                    if (row_count_q != 16'hFFFF) begin
                        row_count_d = row_count_q + 16'd1;
                    end
                    if (chart_addr_q == c_last_addr) begin
                        state_d = S_DONE;
                    end else begin
                        chart_addr_d = chart_addr_q + ADDR_W'(1);
                        state_d      = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign chart_addr   = chart_addr_q;
    assign shift_up     = shift_up_q;
    assign strip_valid  = strip_valid_q;
    assign strip_arrows = strip_arrows_q;
    assign row_count    = row_count_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_FETCH) || (state_q == S_CAPTURE);
    assign done         = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_arrow_row_scheduler.sv
//------------------------------------------------------------------------------
// tb_arrow_row_scheduler: directed checks of arrow_row_scheduler with two configs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_arrow_row_scheduler;

    logic        clk;
    logic        reset;
    logic        vs;
    logic        pause;
    logic        start1, start2;
    logic [7:0]  addr1, addr2;
    logic [4:0]  data1, data2;
    logic        shift_up1, shift_up2;
    logic [3:0]  arrows1, arrows2;
    logic        valid1, valid2;
    logic [15:0] rows1, rows2;
    logic        busy1, busy2;
    logic        done1, done2;

    logic [4:0]  rom1 [256];
    logic [4:0]  rom2 [256];

    int total = 0;
    int bad   = 0;
    int pulses1 = 0;
    int pulses2 = 0;
    int sv_err  = 0;
    int bd_err  = 0;

    arrow_row_scheduler #(.FRAMES_PER_ROW(8), .ADDR_W(8), .CHART_DEPTH(256)) dut1 (
        .clk(clk), .reset(reset), .vs(vs), .start(start1), .pause(pause),
        .chart_addr(addr1), .chart_data(data1), .shift_up(shift_up1),
        .strip_arrows(arrows1), .strip_valid(valid1), .row_count(rows1),
        .busy(busy1), .done(done1)
    );

    arrow_row_scheduler #(.FRAMES_PER_ROW(1), .ADDR_W(8), .CHART_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .vs(vs), .start(start2), .pause(pause),
        .chart_addr(addr2), .chart_data(data2), .shift_up(shift_up2),
        .strip_arrows(arrows2), .strip_valid(valid2), .row_count(rows2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        data1 <= rom1[addr1];
        data2 <= rom2[addr2];
    end

    always @(negedge clk) begin
        if (shift_up1) pulses1++;
        if (shift_up2) pulses2++;
        if (valid1 !== shift_up1 || valid2 !== shift_up2) sv_err++;
        if ((busy1 && done1) || (busy2 && done2)) bd_err++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One VGA frame: low phase then high phase long enough for the resulting shift to land.
    task automatic frame();
        vs = 1'b0;
        step(6);
        vs = 1'b1;
        step(6);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom1[i] = 5'b0_0000;
            rom2[i] = 5'b0_0000;
        end
        rom1[0] = 5'b0_1010;
        rom1[1] = 5'b0_0000;
        rom1[2] = 5'b1_0000;
        rom2[0] = 5'b0_0001;
        rom2[1] = 5'b0_0010;
        rom2[2] = 5'b0_0100;
        rom2[3] = 5'b0_1000;

        reset = 1'b1; vs = 1'b1; pause = 1'b0; start1 = 1'b0; start2 = 1'b0;
        step(3);
        reset = 1'b0;
        check_val("rst_addr",   32'(addr1),     32'h0);
        check_val("rst_shift",  32'(shift_up1), 32'h0);
        check_val("rst_arrows", 32'(arrows1),   32'h0);
        check_val("rst_valid",  32'(valid1),    32'h0);
        check_val("rst_rows",   32'(rows1),     32'h0);
        check_val("rst_busy",   32'(busy1),     32'h0);
        check_val("rst_done",   32'(done1),     32'h0);

        start1 = 1'b1; start2 = 1'b1;
        step(1);
        start1 = 1'b0; start2 = 1'b0;
        step(8);
        check_val("no_false_tick", 32'(pulses2), 32'd0);
        check_val("run_busy1",     32'(busy1),   32'h1);
        check_val("run_busy2",     32'(busy2),   32'h1);

        // First row: 7 frames, then the 8th with cycle-exact latency checks.
        repeat (7) frame();
        check_val("pre_row0_pulses", 32'(pulses1), 32'd0);
        vs = 1'b0;
        step(6);
        vs = 1'b1;
        step(4);
        check_val("lat_early", 32'(shift_up1), 32'h0);
        step(1);
        check_val("lat_shift", 32'(shift_up1), 32'h1);
        check_val("lat_valid", 32'(valid1),    32'h1);
        step(1);
        check_val("lat_one_cycle", 32'(shift_up1), 32'h0);
        step(4);
        check_val("row0_pulses", 32'(pulses1), 32'd1);
        check_val("row0_arrows", 32'(arrows1), 32'hA);
        check_val("row0_rows",   32'(rows1),   32'd1);
        check_val("row0_addr",   32'(addr1),   32'd1);

        // FRAMES_PER_ROW=1, CHART_DEPTH=4 instance has run off the end of its chart.
        check_val("d2_pulses", 32'(pulses2), 32'd4);
        check_val("d2_done",   32'(done2),   32'h1);
        check_val("d2_busy",   32'(busy2),   32'h0);
        check_val("d2_addr",   32'(addr2),   32'd3);
        check_val("d2_rows",   32'(rows2),   32'd4);
        check_val("d2_arrows", 32'(arrows2), 32'h8);

        // Pause across frames 3..6 of the period delays the shift by four ticks.
        frame();
        frame();
        pause = 1'b1;
        repeat (4) frame();
        pause = 1'b0;
        repeat (5) frame();
        check_val("pause_hold", 32'(pulses1), 32'd1);
        frame();
        check_val("pause_row1_pulses", 32'(pulses1), 32'd2);
        check_val("row1_arrows",       32'(arrows1), 32'h0);
        check_val("row1_rows",         32'(rows1),   32'd2);
        check_val("row1_addr",         32'(addr1),   32'd2);

        // Start while running must not reinitialise anything, including the frame count.
        frame();
        frame();
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        step(2);
        check_val("start_run_rows", 32'(rows1), 32'd2);
        check_val("start_run_addr", 32'(addr1), 32'd2);
        check_val("start_run_busy", 32'(busy1), 32'h1);
        repeat (6) frame();
        check_val("end_pulses", 32'(pulses1), 32'd2);
        check_val("end_done",   32'(done1),   32'h1);
        check_val("end_busy",   32'(busy1),   32'h0);
        check_val("end_rows",   32'(rows1),   32'd2);
        check_val("end_addr",   32'(addr1),   32'd2);

        // Restart from DONE.
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        check_val("restart_rows",   32'(rows1),   32'd0);
        check_val("restart_addr",   32'(addr1),   32'd0);
        check_val("restart_busy",   32'(busy1),   32'h1);
        check_val("restart_done",   32'(done1),   32'h0);
        check_val("restart_arrows", 32'(arrows1), 32'h0);
        repeat (8) frame();
        check_val("restart_pulses", 32'(pulses1), 32'd3);
        check_val("restart_arrows2", 32'(arrows1), 32'hA);
        check_val("restart_rows2",  32'(rows1),   32'd1);

        // Reset asserted while in FETCH.
        repeat (7) frame();
        vs = 1'b0;
        step(6);
        vs = 1'b1;
        step(3);
        check_val("fetch_busy", 32'(busy1), 32'h1);
        reset = 1'b1;
        #1;
        check_val("midrst_addr",   32'(addr1),     32'h0);
        check_val("midrst_rows",   32'(rows1),     32'h0);
        check_val("midrst_arrows", 32'(arrows1),   32'h0);
        check_val("midrst_busy",   32'(busy1),     32'h0);
        check_val("midrst_done",   32'(done1),     32'h0);
        check_val("midrst_shift",  32'(shift_up1), 32'h0);
        step(3);
        reset = 1'b0;
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        step(10);
        check_val("post_rst_pulses1", 32'(pulses1), 32'd3);
        check_val("post_rst_pulses2", 32'(pulses2), 32'd4);
        check_val("post_rst_busy2",   32'(busy2),   32'h1);
        check_val("post_rst_busy1",   32'(busy1),   32'h0);

        check_val("valid_eq_shift", 32'(sv_err), 32'd0);
        check_val("busy_done_excl", 32'(bd_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
